tinyqv_intc: RTL and testbench
==============================

Name: tinyqv_intc

Overview:
- Parametrised nibble-serial interrupt controller for the TinyQV core; generalises the fixed 4-line mip/mie logic to NUM_IRQ lines.
- Per-channel edge/level mode is software-programmable, with fixed priority.
- Exposes mie (0x304), mip (0x344) and a custom mode CSR (0x7C0) over the core's 4-bit counter-sequenced CSR datapath.
- Drives interrupt_pending and the latched interrupt ID that the core uses to form mcause.

Parameters:
- NUM_IRQ, 8, number of interrupt lines, 1..16; occupy CSR bits 16+i.
- EDGE_RESET, 16'h0003, reset value of the mode CSR; bit i=1 means channel i is edge-triggered.

Ports:
- clk  input  1  clock, rising-edge.
- rstn  input  1  asynchronous active-low reset.
- irq_in  input  NUM_IRQ  raw interrupt lines, asynchronous to clk.
- counter  input  3  core sub-cycle counter, increments every clock.
- csr_addr  input  12  CSR address of the current instruction.
- csr_op  input  2  00 none, 01 write, 10 set, 11 clear.
- csr_wdata  input  4  rs1 nibble for the current counter.
- csr_rdata  output  4  read nibble for the current counter.
- global_ie  input  1  mstatus.MIE.
- take_irq  input  1  core is entering the interrupt handler; valid only when counter==0.
- interrupt_pending  output  1  global_ie && |(mip & mie).
- irq_id  output  4  index of the channel taken, latched.

Behaviour:
- Reset (rstn low, async):
  - sync1, sync2, prev, pending, mie all clear to 0; mode loads EDGE_RESET[NUM_IRQ-1:0].
  - irq_id resets to 0; csr_rdata reads 0 (csr_op is assumed 00 during reset).
- Synchroniser: sync1<=irq_in; sync2<=sync1; prev<=sync2, every clock.
- Edge channel i:
  - pending[i] is set on the clock where sync2[i] && !prev[i].
  - A rising edge of irq_in becomes visible in mip 3 clocks later.
- Level channel i: mip[i]=sync2[i], visible 2 clocks after irq_in rises. pending[i] is ignored but retained.
- mip[i] = mode[i] ? pending[i] : sync2[i].
- CSR bit b = 16+i maps to nibble k=b/4-4, transferred at counter==4+k. At counter 0..3, and for bits >=16+NUM_IRQ, reads return 0 and writes are ignored.
- Writes (applied at the clock edge ending counter 4+k, when csr_op!=00):
  - mie: write replaces, set ORs, clear ANDs with the inverted nibble.
  - mode: same three ops.
  - mip: the op acts on pending (edge channels only). Writes to level-channel bits are ignored.
- Simultaneous hardware edge and software clear/write-0 on the same pending bit: hardware set wins, and the bit ends as 1.
- A mode change does not modify pending.
- Read: csr_rdata = the addressed register's nibble at counter 4+k. Unknown addresses or csr_op irrelevant → reads 0.
- Priority: the lowest index in (mip & mie) wins.
- On take_irq && counter==0:
  - irq_id <= the winning index; the core forms mcause = 0x80000010 + irq_id.
  - If no channel wins, irq_id is unchanged.
  - take_irq at counter!=0 is ignored.
- interrupt_pending is combinational from registers plus global_ie; there is no added latency.
- Reset asserted mid-CSR-access aborts the access; all state takes its reset values.

Optional Feature:
- Macro: TINYQV_INTC_AUTO_CLEAR_EN.
- Defined: on take_irq && counter==0, the winning channel's pending bit is cleared when that channel is edge mode. A same-clock new edge on that channel wins, and the bit stays 1.
- Undefined: pending bits clear only by software mip write/clear.
- Level channels are never affected by this macro.

Test Plan:
- Reset with EDGE_RESET=16'h0003 → read 0x7C0 gives nibble 4 = 4'h3, nibble 5 = 4'h0; mie=0; mip=0; interrupt_pending=0.
- irq_in[0] pulses 1 for 1 clock, mie=1 via write nibble 4 = 4'h1, global_ie=1 → mip bit16 set exactly 3 clocks after the rise; interrupt_pending=1.
- Then clear mip nibble 4 = 4'h1 → pending drops and interrupt_pending=0.
- Level channel 5 (mode[5]=0) held high, mie[5]=1 → mip nibble 5 = 4'h2.
- Drop irq_in[5] → mip bit 21 clears 2 clocks later.
- irq 3 and irq 6 pending, both enabled, take_irq at counter 0 → irq_id=3.
- With TINYQV_INTC_AUTO_CLEAR_EN, irq3 edge mode → pending[3] clears; without it, pending[3] stays 1.
- Software clear of pending[2] at counter 4 coincides with sync2[2] rising edge → pending[2]=1 afterwards.
- Write mie via csr_op=01, nibble 4 = 4'hF, nibble 5 = 4'hF with NUM_IRQ=6 → mie reads back nibble 4 = 4'hF, nibble 5 = 4'h3.

Source files
------------

// File: rtl/tinyqv_intc_if.sv
// tinyqv_intc_if
//   Nibble-serial CSR bus between the TinyQV core and the interrupt controller.
//   One CSR access spans eight clocks; `counter` selects the active nibble.
//   Signals:
//     counter   - core sub-cycle counter, increments every clock
//     csr_addr  - 12-bit CSR address of the current instruction
//     csr_op    - 00 none, 01 write, 10 set, 11 clear
//     csr_wdata - rs1 nibble for the current counter value
//     csr_rdata - read nibble for the current counter value
//   Modports: master (core side), slave (controller side).
interface tinyqv_intc_if;
   logic [2:0]  counter;
   logic [11:0] csr_addr;
   logic [1:0]  csr_op;
   logic [3:0]  csr_wdata;
   logic [3:0]  csr_rdata;

   modport master (output counter, csr_addr, csr_op, csr_wdata, input csr_rdata);
   modport slave  (input counter, csr_addr, csr_op, csr_wdata, output csr_rdata);
endinterface

// File: rtl/tinyqv_intc.sv
// tinyqv_intc
//   Parametrised interrupt controller for the TinyQV core. NUM_IRQ lines map to
//   CSR bits 16+i of mie (0x304), mip (0x344) and the mode CSR (0x7C0), which
//   are accessed over the core's 4-bit counter-sequenced CSR datapath.
//   Each channel is edge (mode=1, latched in pending) or level (mode=0) triggered;
//   the lowest enabled pending index wins.
//   Ports:
//     clk               - rising-edge clock
//     rstn              - asynchronous active-low reset
//     irq_in            - raw interrupt lines, asynchronous to clk
//     csr               - CSR bus (tinyqv_intc_if.slave)
//     global_ie         - mstatus.MIE
//     take_irq          - core is entering the handler (valid when counter==0)
//     interrupt_pending - global_ie && |(mip & mie)
//     irq_id            - latched index of the taken channel
//   Optional build macro: TINYQV_INTC_AUTO_CLEAR_EN - when defined, taking an
//   interrupt clears the winning channel's pending bit if it is edge mode.
module tinyqv_intc #(
   parameter int unsigned NUM_IRQ    = 8,
   parameter logic [15:0] EDGE_RESET = 16'h0003
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [NUM_IRQ-1:0] irq_in,
   tinyqv_intc_if.slave       csr,
   input  logic               global_ie,
   input  logic               take_irq,
   output logic               interrupt_pending,
   output logic [3:0]         irq_id
);

   typedef enum logic [1:0] {
      OP_NONE  = 2'b00,
      OP_WRITE = 2'b01,
      OP_SET   = 2'b10,
      OP_CLEAR = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      SEL_NONE,
      SEL_MIE,
      SEL_MIP,
      SEL_MODE
   } sel_e;

   localparam logic [11:0] ADDR_MIE  = 12'h304;
   localparam logic [11:0] ADDR_MIP  = 12'h344;
   localparam logic [11:0] ADDR_MODE = 12'h7C0;

`ifdef TINYQV_INTC_AUTO_CLEAR_EN
   localparam bit AutoClear = 1'b1;
`else
   localparam bit AutoClear = 1'b0;
`endif

   logic [NUM_IRQ-1:0] sync1_q, sync2_q, prev_q;
   logic [NUM_IRQ-1:0] pending_q, pending_d;
   logic [NUM_IRQ-1:0] mie_q, mie_d;
   logic [NUM_IRQ-1:0] mode_q, mode_d;
   logic [3:0]         irq_id_q, irq_id_d;

   logic [NUM_IRQ-1:0] mip, active, win_oh, edge_set, pend_sw;
   logic [15:0]        mie_w, mip_w, mode_w, pend_w;
   logic [3:0]         mie_nib, mip_nib, mode_nib, pend_nib, rd_nib;
   logic [3:0]         mie_new, mode_new, pend_new;
   logic               nib_valid, wr_en, take_ok, win_found;
   logic [1:0]         nib;
   op_e                op;
   sel_e               sel;
   logic [3:0]         win_idx;

   function automatic logic [3:0] op_nib(input logic [3:0] old, input logic [3:0] wd,
                                         input op_e o);
      logic [3:0] r;
      r = old;
      case (o)
         OP_WRITE: r = wd;
         OP_SET:   r = old | wd;
         OP_CLEAR: r = old & ~wd;
         default:  r = old;
      endcase
      return r;
   endfunction

   // Nibbles 0..3 of the upper halfword are transferred at counter 4..7.
   assign nib_valid = csr.counter[2];
   assign nib       = csr.counter[1:0];
   assign op        = op_e'(csr.csr_op);
   assign wr_en     = nib_valid && (op != OP_NONE);
   assign take_ok   = take_irq && (csr.counter == 3'd0);

   always_comb begin
      case (csr.csr_addr)
         ADDR_MIE:  sel = SEL_MIE;
         ADDR_MIP:  sel = SEL_MIP;
         ADDR_MODE: sel = SEL_MODE;
         default:   sel = SEL_NONE;
      endcase
   end

   assign mip      = (mode_q & pending_q) | (~mode_q & sync2_q);
   assign active   = mip & mie_q;
   // Isolate the lowest set bit: lowest index has highest priority.
   assign win_oh   = active & (~active + 1'b1);
   assign edge_set = sync2_q & ~prev_q & mode_q;

   assign interrupt_pending = global_ie && (|active);

   always_comb begin
      win_found = |active;
      win_idx   = '0;
      for (int unsigned i = 0; i < NUM_IRQ; i++) begin
         if (win_oh[i]) win_idx = 4'(i);
      end
   end

   // Upper-halfword views padded with zeros above NUM_IRQ.
   always_comb begin
      mie_w  = '0;
      mip_w  = '0;
      mode_w = '0;
      pend_w = '0;
      mie_w[NUM_IRQ-1:0]  = mie_q;
      mip_w[NUM_IRQ-1:0]  = mip;
      mode_w[NUM_IRQ-1:0] = mode_q;
      pend_w[NUM_IRQ-1:0] = pending_q;
      mie_nib  = mie_w[{nib, 2'b00} +: 4];
      mip_nib  = mip_w[{nib, 2'b00} +: 4];
      mode_nib = mode_w[{nib, 2'b00} +: 4];
      pend_nib = pend_w[{nib, 2'b00} +: 4];
   end

   always_comb begin
      case (sel)
         SEL_MIE:  rd_nib = mie_nib;
         SEL_MIP:  rd_nib = mip_nib;
         SEL_MODE: rd_nib = mode_nib;
         default:  rd_nib = '0;
      endcase
      csr.csr_rdata = (rstn && nib_valid) ? rd_nib : '0;
   end

   assign mie_new  = op_nib(mie_nib, csr.csr_wdata, op);
   assign mode_new = op_nib(mode_nib, csr.csr_wdata, op);
   assign pend_new = op_nib(pend_nib, csr.csr_wdata, op);

   always_comb begin
      mie_d   = mie_q;
      mode_d  = mode_q;
      pend_sw = pending_q;
      for (int unsigned i = 0; i < NUM_IRQ; i++) begin
         if (wr_en && (2'(i >> 2) == nib)) begin
            if (sel == SEL_MIE)               mie_d[i]   = mie_new[2'(i & 3)];
            if (sel == SEL_MODE)              mode_d[i]  = mode_new[2'(i & 3)];
            // mip writes reach pending only on edge channels.
            if (sel == SEL_MIP && mode_q[i])  pend_sw[i] = pend_new[2'(i & 3)];
         end
      end
      if (AutoClear && take_ok) pend_sw = pend_sw & ~(win_oh & mode_q);
      // Hardware edge is ORed last so it beats a same-clock software clear.
      pending_d = pend_sw | edge_set;
      irq_id_d  = (take_ok && win_found) ? win_idx : irq_id_q;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         prev_q    <= '0;
         pending_q <= '0;
         mie_q     <= '0;
         mode_q    <= EDGE_RESET[NUM_IRQ-1:0];
         irq_id_q  <= '0;
      end else begin
         sync1_q   <= irq_in;
         sync2_q   <= sync1_q;
         prev_q    <= sync2_q;
         pending_q <= pending_d;
         mie_q     <= mie_d;
         mode_q    <= mode_d;
         irq_id_q  <= irq_id_d;
      end
   end

   assign irq_id = irq_id_q;

endmodule

// File: tb/tb_tinyqv_intc.sv
module tb_tinyqv_intc;

   logic       clk;
   logic       rstn;
   logic [7:0] irq_in;
   logic       global_ie;
   logic       take_irq;
   logic       ip8, ip6;
   logic [3:0] id8, id6;

   int checks = 0;
   int errors = 0;

   tinyqv_intc_if bus ();
   tinyqv_intc_if bus6 ();

   assign bus6.counter   = bus.counter;
   assign bus6.csr_addr  = bus.csr_addr;
   assign bus6.csr_op    = bus.csr_op;
   assign bus6.csr_wdata = bus.csr_wdata;

   tinyqv_intc #(.NUM_IRQ(8), .EDGE_RESET(16'h0003)) dut (
      .clk(clk), .rstn(rstn), .irq_in(irq_in), .csr(bus),
      .global_ie(global_ie), .take_irq(take_irq),
      .interrupt_pending(ip8), .irq_id(id8)
   );

   tinyqv_intc #(.NUM_IRQ(6), .EDGE_RESET(16'h0003)) dut6 (
      .clk(clk), .rstn(rstn), .irq_in(irq_in[5:0]), .csr(bus6),
      .global_ie(global_ie), .take_irq(take_irq),
      .interrupt_pending(ip6), .irq_id(id6)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
      bus.counter = bus.counter + 3'd1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One 8-clock CSR access aligned to counter==0. Junk wdata 4'hF is driven at
   // counter 0..3 where it must be ignored. raise2 lines go high during counter 2.
   task automatic csr_acc(input logic [11:0] addr, input logic [1:0] op, input logic [15:0] wd,
                          input logic [7:0] raise2, output logic [15:0] rd8, output logic [15:0] rd6);
      rd8 = '0;
      rd6 = '0;
      while (bus.counter != 3'd0) tick();
      bus.csr_addr = addr;
      bus.csr_op   = op;
      for (int c = 0; c < 8; c++) begin
         if (c == 2) irq_in = irq_in | raise2;
         bus.csr_wdata = (c >= 4) ? wd[(c-4)*4 +: 4] : 4'hF;
         @(negedge clk);
         if (c >= 4) begin
            rd8[(c-4)*4 +: 4] = bus.csr_rdata;
            rd6[(c-4)*4 +: 4] = bus6.csr_rdata;
         end
         tick();
      end
      bus.csr_op    = 2'b00;
      bus.csr_addr  = 12'h000;
      bus.csr_wdata = 4'h0;
   endtask

   task automatic rd(input logic [11:0] addr, output logic [15:0] v);
      logic [15:0] d6;
      csr_acc(addr, 2'b00, 16'h0000, 8'h00, v, d6);
   endtask

   task automatic wr(input logic [11:0] addr, input logic [1:0] op, input logic [15:0] wd);
      logic [15:0] d8, d6;
      csr_acc(addr, op, wd, 8'h00, d8, d6);
   endtask

   task automatic take_at0();
      while (bus.counter != 3'd0) tick();
      take_irq = 1'b1;
      tick();
      take_irq = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      logic [15:0] v, v6;
      logic        autoclr;
`ifdef TINYQV_INTC_AUTO_CLEAR_EN
      autoclr = 1'b1;
`else
      autoclr = 1'b0;
`endif
      rstn          = 1'b0;
      irq_in        = '0;
      global_ie     = 1'b0;
      take_irq      = 1'b0;
      bus.counter   = 3'd0;
      bus.csr_addr  = 12'h7C0;
      bus.csr_op    = 2'b00;
      bus.csr_wdata = 4'h0;

      // Reset state
      repeat (4) tick();
      @(negedge clk);
      chk("reset_rdata", 32'(bus.csr_rdata), 32'h0);
      chk("reset_ip", 32'(ip8), 32'h0);
      chk("reset_id", 32'(id8), 32'h0);
      rstn = 1'b1;
      tick();

      rd(12'h7C0, v); chk("mode_reset", 32'(v), 32'h0003);
      rd(12'h304, v); chk("mie_reset", 32'(v), 32'h0000);
      rd(12'h344, v); chk("mip_reset", 32'(v), 32'h0000);
      chk("ip_reset", 32'(ip8), 32'h0);

      // Edge channel 0: 3-clock latency
      wr(12'h304, 2'b01, 16'h0001);
      global_ie = 1'b1;
      rd(12'h304, v); chk("mie_wr0", 32'(v), 32'h0001);
      irq_in[0] = 1'b1;
      tick();
      irq_in[0] = 1'b0;
      @(negedge clk); chk("edge_lat1", 32'(ip8), 32'h0);
      tick();
      @(negedge clk); chk("edge_lat2", 32'(ip8), 32'h0);
      tick();
      @(negedge clk); chk("edge_lat3", 32'(ip8), 32'h1);
      rd(12'h344, v); chk("mip_edge0", 32'(v), 32'h0001);
      wr(12'h344, 2'b11, 16'h0001);
      rd(12'h344, v); chk("mip_clr0", 32'(v), 32'h0000);
      chk("ip_clr0", 32'(ip8), 32'h0);

      // Level channel 5: 2-clock latency both ways
      wr(12'h304, 2'b01, 16'h0020);
      irq_in[5] = 1'b1;
      tick();
      @(negedge clk); chk("lvl_rise1", 32'(ip8), 32'h0);
      tick();
      @(negedge clk); chk("lvl_rise2", 32'(ip8), 32'h1);
      rd(12'h344, v); chk("mip_lvl5", 32'(v), 32'h0020);
      irq_in[5] = 1'b0;
      tick();
      @(negedge clk); chk("lvl_fall1", 32'(ip8), 32'h1);
      tick();
      @(negedge clk); chk("lvl_fall2", 32'(ip8), 32'h0);

      // Priority: channels 3 and 6 edge, both enabled
      wr(12'h7C0, 2'b10, 16'h0048);
      rd(12'h7C0, v); chk("mode_set", 32'(v), 32'h004B);
      wr(12'h304, 2'b01, 16'h0048);
      irq_in[3] = 1'b1;
      irq_in[6] = 1'b1;
      tick();
      irq_in[3] = 1'b0;
      irq_in[6] = 1'b0;
      repeat (3) tick();
      @(negedge clk); chk("ip_36", 32'(ip8), 32'h1);
      rd(12'h344, v); chk("mip_36", 32'(v), 32'h0048);
      tick();
      tick();
      take_irq = 1'b1;
      tick();
      take_irq = 1'b0;
      @(negedge clk); chk("take_ctr2_ignored", 32'(id8), 32'h0);
      take_at0();
      chk("take_id3", 32'(id8), 32'h3);
      rd(12'h344, v); chk("mip_after_take", 32'(v), autoclr ? 32'h0040 : 32'h0048);
      take_at0();
      chk("take_second", 32'(id8), autoclr ? 32'h6 : 32'h3);

      wr(12'h304, 2'b11, 16'h0008);
      rd(12'h304, v); chk("mie_clrop", 32'(v), 32'h0040);

      // Software clear of pending[2] coinciding with its hardware edge
      wr(12'h7C0, 2'b10, 16'h0004);
      csr_acc(12'h344, 2'b11, 16'h0004, 8'h04, v, v6);
      irq_in[2] = 1'b0;
      rd(12'h344, v); chk("hw_beats_sw", 32'(v), autoclr ? 32'h0004 : 32'h004C);

      // Mode change leaves pending intact
      wr(12'h7C0, 2'b11, 16'h0004);
      rd(12'h344, v); chk("mip_as_level", 32'(v), autoclr ? 32'h0000 : 32'h0048);
      wr(12'h7C0, 2'b10, 16'h0004);
      rd(12'h344, v); chk("mip_back_edge", 32'(v), autoclr ? 32'h0004 : 32'h004C);

      rd(12'h300, v); chk("unknown_addr", 32'(v), 32'h0000);

      // Bits above NUM_IRQ read 0 and ignore writes
      wr(12'h304, 2'b01, 16'h00FF);
      csr_acc(12'h304, 2'b00, 16'h0000, 8'h00, v, v6);
      chk("mie_ff_n8", 32'(v), 32'h00FF);
      chk("mie_ff_n6", 32'(v6), 32'h003F);

      global_ie = 1'b0;
      @(negedge clk); chk("ip_gie0", 32'(ip8), 32'h0);
      global_ie = 1'b1;
      @(negedge clk); chk("ip_gie1", 32'(ip8), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
